// File: rtl/fb_wr_arbiter.sv
// Arbitrates the single vga_fb write port between the pixel producer and the UART
// debug loader, registers the winning beat and flags the last PPU beat of each frame.
module fb_wr_arbiter #(
   parameter int MAX_PPU_RUN  = 16,
   parameter int FRAME_PIXELS = 61440
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ppu_valid,
   input  logic [7:0] ppu_x,
   input  logic [7:0] ppu_y,
   input  logic [5:0] ppu_col,
   output logic       ppu_ready,
   input  logic       dbg_valid,
   input  logic [7:0] dbg_x,
   input  logic [7:0] dbg_y,
   input  logic [5:0] dbg_col,
   output logic       dbg_ready,
   input  logic       dbg_lock,
   output logic       fb_we,
   output logic [7:0] fb_x,
   output logic [7:0] fb_y,
   output logic [5:0] fb_di,
   output logic       frame_done,
   output logic [4:0] starve_cnt,
   output logic [1:0] arb_state
);

   // Handshake: a beat transfers when valid && ready in the same cycle. Ready is
   // combinational from valid, state and the run counter, and the two readies are
   // mutually exclusive. A requester holds x/y/col stable while valid && !ready.

   typedef enum logic [1:0] {
      S_PPU  = 2'd0,
      S_DBG  = 2'd1,
      S_LOCK = 2'd2
   } state_t;

   localparam logic [4:0]  RUN_MAX    = 5'(MAX_PPU_RUN);
   localparam logic [15:0] FRAME_LAST = 16'(FRAME_PIXELS - 1);

   state_t      state, state_nxt;
   logic [4:0]  run_cnt, run_nxt;
   logic [15:0] frame_cnt;
   logic        run_full;
   logic        ppu_xfer, dbg_xfer;

   assign run_full   = (run_cnt == RUN_MAX);
   assign ppu_xfer   = ppu_valid && ppu_ready;
   assign dbg_xfer   = dbg_valid && dbg_ready;
   assign starve_cnt = run_cnt;
   assign arb_state  = state;

   // S_DBG marks the cycle after a forced loader grant; the grant itself was taken on
   // entry, so S_DBG arbitrates like S_PPU with the run counter already cleared.
   always_comb begin
      state_nxt = state;
      ppu_ready = 1'b0;
      dbg_ready = 1'b0;
      run_nxt   = run_cnt;
      case (state)
         S_PPU, S_DBG: begin
            if (dbg_valid && run_full) begin
               dbg_ready = 1'b1;
               state_nxt = S_DBG;
            end else begin
               ppu_ready = ppu_valid;
               dbg_ready = dbg_valid && !ppu_valid;
               state_nxt = S_PPU;
            end
         end
         S_LOCK: begin
            dbg_ready = dbg_valid;
            state_nxt = S_PPU;
         end
         default: state_nxt = S_PPU;
      endcase
      if (dbg_lock)
         state_nxt = S_LOCK;
      if (!rst) begin
         ppu_ready = 1'b0;
         dbg_ready = 1'b0;
      end
      if (state == S_LOCK || !dbg_valid || dbg_ready)
         run_nxt = 5'd0;
      else if (ppu_valid && ppu_ready && !run_full)
         run_nxt = run_cnt + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_PPU;
         run_cnt    <= 5'd0;
         frame_cnt  <= 16'd0;
         fb_we      <= 1'b0;
         fb_x       <= 8'd0;
         fb_y       <= 8'd0;
         fb_di      <= 6'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         run_cnt    <= run_nxt;
         fb_we      <= ppu_xfer || dbg_xfer;
         frame_done <= 1'b0;
         if (ppu_xfer) begin
            fb_x  <= ppu_x;
            fb_y  <= ppu_y;
            fb_di <= ppu_col;
            // Only PPU beats advance the frame position.
            if (frame_cnt == FRAME_LAST) begin
               frame_cnt  <= 16'd0;
               frame_done <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end else if (dbg_xfer) begin
            fb_x  <= dbg_x;
            fb_y  <= dbg_y;
            fb_di <= dbg_col;
         end
      end
   end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Directed bench for fb_wr_arbiter: reset, loader-only, mid-run reset, full frame
// with a stall, PPU/loader fairness pattern and debug lock.
module tb_fb_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       ppu_valid, dbg_valid, dbg_lock;
   logic [7:0] ppu_x, ppu_y, dbg_x, dbg_y;
   logic [5:0] ppu_col, dbg_col;
   logic       ppu_ready, dbg_ready;
   logic       fb_we, frame_done;
   logic [7:0] fb_x, fb_y;
   logic [5:0] fb_di;
   logic [4:0] starve_cnt;
   logic [1:0] arb_state;

   int n_vec  = 0;
   int n_miss = 0;
   logic [21:0] exp_q[$];

   always #5 clk = ~clk;

   fb_wr_arbiter dut (
      .clk(clk), .rst(rst),
      .ppu_valid(ppu_valid), .ppu_x(ppu_x), .ppu_y(ppu_y), .ppu_col(ppu_col),
      .ppu_ready(ppu_ready),
      .dbg_valid(dbg_valid), .dbg_x(dbg_x), .dbg_y(dbg_y), .dbg_col(dbg_col),
      .dbg_ready(dbg_ready), .dbg_lock(dbg_lock),
      .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_di(fb_di),
      .frame_done(frame_done), .starve_cnt(starve_cnt), .arb_state(arb_state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop(input string tag);
      logic [21:0] exp;
      exp = exp_q.pop_front();
      chk({tag, "_we"}, 32'(fb_we), 32'd1);
      chk({tag, "_beat"}, 32'({fb_x, fb_y, fb_di}), 32'(exp));
   endtask

   int n_we, n_done, done_at, stall_we, ready_miss;
   logic [7:0] done_x, done_y;
   logic [5:0] done_di;

   initial begin
      // reset: readies gated off even with a valid beat present
      rst = 1'b0; dbg_lock = 1'b0; dbg_valid = 1'b0; ppu_valid = 1'b1;
      ppu_x = 8'd1; ppu_y = 8'd2; ppu_col = 6'd3;
      dbg_x = 8'd0; dbg_y = 8'd0; dbg_col = 6'd0;
      #1;
      chk("rst_ppu_ready", 32'(ppu_ready), 32'd0);
      tick(); tick();
      chk("rst_fb_we", 32'(fb_we), 32'd0);
      chk("rst_fb_xydi", 32'({fb_x, fb_y, fb_di}), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_starve", 32'(starve_cnt), 32'd0);
      chk("rst_state", 32'(arb_state), 32'd0);
      ppu_valid = 1'b0; rst = 1'b1;
      tick();

      // loader only
      dbg_valid = 1'b1; dbg_x = 8'd7; dbg_y = 8'd9; dbg_col = 6'h14;
      #1;
      chk("dbg_only_ready", 32'(dbg_ready), 32'd1);
      chk("dbg_only_ppu_ready", 32'(ppu_ready), 32'd0);
      tick();
      chk("dbg_only_we", 32'(fb_we), 32'd1);
      chk("dbg_only_beat", 32'({fb_x, fb_y, fb_di}), 32'({8'd7, 8'd9, 6'h14}));
      dbg_valid = 1'b0;
      tick();
      chk("dbg_only_we_off", 32'(fb_we), 32'd0);
      chk("dbg_only_hold_di", 32'(fb_di), 32'h14);

      // reset the cycle after a PPU accept
      for (int i = 0; i < 3; i++) begin
         ppu_valid = 1'b1; ppu_x = 8'(8'h50 + i); ppu_y = 8'd1; ppu_col = 6'(i);
         tick();
      end
      chk("pre_rst_we", 32'(fb_we), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_ppu_ready", 32'(ppu_ready), 32'd0);
      tick();
      chk("mid_rst_we", 32'(fb_we), 32'd0);
      chk("mid_rst_xydi", 32'({fb_x, fb_y, fb_di}), 32'd0);
      rst = 1'b1; ppu_valid = 1'b0;
      tick();

      // full frame in raster order with a 100-cycle stall at beat 30000
      n_we = 0; n_done = 0; done_at = 0; stall_we = 0; ready_miss = 0;
      done_x = 8'd0; done_y = 8'd0; done_di = 6'd0;
      for (int b = 0; b < 61440; b++) begin
         if (b == 30000) begin
            ppu_valid = 1'b0;
            for (int s = 0; s < 100; s++) begin
               tick();
               if (fb_we) stall_we++;
               if (frame_done) n_done++;
            end
         end
         ppu_valid = 1'b1;
         ppu_x = b[7:0]; ppu_y = b[15:8]; ppu_col = 6'(b[7:0] + b[15:8]);
         #1;
         if (!ppu_ready) ready_miss++;
         tick();
         if (fb_we) n_we++;
         if (frame_done) begin
            n_done++; done_at = n_we; done_x = fb_x; done_y = fb_y; done_di = fb_di;
         end
      end
      ppu_valid = 1'b0;
      tick();
      chk("frame_we_after", 32'(fb_we), 32'd0);
      chk("frame_done_after", 32'(frame_done), 32'd0);
      chk("frame_n_we", 32'(n_we), 32'd61440);
      chk("frame_n_done", 32'(n_done), 32'd1);
      chk("frame_done_at", 32'(done_at), 32'd61440);
      chk("frame_done_x", 32'(done_x), 32'd255);
      chk("frame_done_y", 32'(done_y), 32'd239);
      chk("frame_done_di", 32'(done_di), 32'h2E);
      chk("frame_stall_we", 32'(stall_we), 32'd0);
      chk("frame_ready_miss", 32'(ready_miss), 32'd0);

      // both valid continuously: 16 PPU grants, then one loader grant
      ppu_valid = 1'b1; ppu_x = 8'd10; ppu_y = 8'd20; ppu_col = 6'h11;
      dbg_valid = 1'b1; dbg_x = 8'd3; dbg_y = 8'd5; dbg_col = 6'h27;
      for (int k = 0; k < 34; k++) begin
         #1;
         chk("fair_starve", 32'(starve_cnt), 32'(k % 17));
         if (k % 17 == 16) begin
            chk("fair_dbg_ready", 32'(dbg_ready), 32'd1);
            chk("fair_ppu_ready", 32'(ppu_ready), 32'd0);
            exp_q.push_back({8'd3, 8'd5, 6'h27});
         end else begin
            chk("fair_dbg_ready", 32'(dbg_ready), 32'd0);
            chk("fair_ppu_ready", 32'(ppu_ready), 32'd1);
            exp_q.push_back({8'd10, 8'd20, 6'h11});
         end
         tick();
         sb_pop("fair");
         chk("fair_state", 32'(arb_state), (k % 17 == 16) ? 32'd1 : 32'd0);
      end
      ppu_valid = 1'b0; dbg_valid = 1'b0;
      tick();

      // debug lock: PPU blocked, every loader beat written
      dbg_lock = 1'b1;
      tick();
      chk("lock_state", 32'(arb_state), 32'd2);
      ppu_valid = 1'b1; dbg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dbg_x = 8'(i); dbg_y = 8'd100; dbg_col = 6'(6'h30 + i);
         #1;
         chk("lock_ppu_ready", 32'(ppu_ready), 32'd0);
         chk("lock_dbg_ready", 32'(dbg_ready), 32'd1);
         chk("lock_starve", 32'(starve_cnt), 32'd0);
         exp_q.push_back({8'(i), 8'd100, 6'(6'h30 + i)});
         tick();
         sb_pop("lock");
      end
      dbg_lock = 1'b0; dbg_x = 8'd9; dbg_col = 6'h3F;
      #1;
      chk("unlock_ppu_ready0", 32'(ppu_ready), 32'd0);
      chk("unlock_dbg_ready0", 32'(dbg_ready), 32'd1);
      exp_q.push_back({8'd9, 8'd100, 6'h3F});
      tick();
      sb_pop("unlock_dbg");
      dbg_valid = 1'b0;
      #1;
      chk("unlock_ppu_ready1", 32'(ppu_ready), 32'd1);
      exp_q.push_back({8'd10, 8'd20, 6'h11});
      tick();
      sb_pop("unlock_ppu");
      ppu_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
